divider: RTL and testbench
==========================

// Module: divider
// PURPOSE
//  Iterative radix-2 restoring divider: the companion to the combinational multiplier in the EX stage.
//  Implements the RV32M DIV, DIVU, REM and REMU operations.
//  Runs as a multi-cycle unit: the pipeline issues with start_i, stalls on busy_o, and captures div_result_o on valid_o.
// PARAMETERS
//  XLEN  32  operand/result width; the iteration count equals XLEN
// PORTS
//  clk_i          in   1     clock; all state changes on the rising edge
//  rst_n_i        in   1     asynchronous active-low reset
//  start_i        in   1     issue request; accepted only while busy_o==0
//  flush_i        in   1     pipeline flush; aborts any operation in flight
//  operand_a_i    in   XLEN  dividend (rs1); sampled only on accept
//  operand_b_i    in   XLEN  divisor (rs2); sampled only on accept
//  div_op_type_i  in   2     DIV_OP_DIV / DIV_OP_DIVU / DIV_OP_REM / DIV_OP_REMU; sampled only on accept
//  busy_o         out  1     unit occupied (state CALC or FIXUP)
//  valid_o        out  1     one-cycle pulse: div_result_o is valid
//  div_result_o   out  XLEN  quotient or remainder; held until the next accept
// BEHAVIOUR
//  Reset (async, rst_n_i=0): state=IDLE, counter=0, busy_o=0, valid_o=0, div_result_o=0, all datapath regs=0.
//  States:
//   IDLE:  accept start -> CALC, or -> DONE via fast path.
//   CALC:  one restoring step per cycle, XLEN cycles.
//   FIXUP: apply signs, write result.
//   DONE:  valid_o=1 for exactly 1 cycle, then -> IDLE.
//  Accept = start_i && !busy_o, so a start issued in DONE is accepted (back-to-back issue).
//   On accept, latch the op type and the absolute values of the operands.
//   Signed ops (DIV/REM): |x| = x[XLEN-1] ? -x : x.
//   Unsigned ops (DIVU/REMU): operands are taken raw.
//   Latch neg_q = a[XLEN-1]^b[XLEN-1] and neg_r = a[XLEN-1]; both are forced to 0 for unsigned ops.
//  CALC step (remainder register R of XLEN+1 bits, quotient/shift register Q):
//   {R,Q} <<= 1; trial = R - {1'b0,|b|}.
//   If trial >= 0 (no borrow): R = trial, Q[0] = 1; otherwise Q[0] = 0.
//   The counter runs XLEN-1 down to 0; the step at counter 0 is the last, then -> FIXUP.
//  FIXUP: quotient = neg_q ? -Q : Q; remainder = neg_r ? -R[XLEN-1:0] : R[XLEN-1:0].
//   div_result_o = quotient for DIV/DIVU, remainder for REM/REMU.
//  Latency, counted from the accept edge k:
//   normal path: CALC in cycles k+1..k+XLEN, FIXUP in k+XLEN+1, valid_o in cycle k+XLEN+2.
//   fast path: valid_o in cycle k+1.
//  Fast paths (decided at accept; CALC is skipped, state goes straight to DONE):
//   divisor==0: quotient = all ones (DIV and DIVU); remainder = dividend (REM and REMU).
//   signed overflow, DIV/REM with a=0x80000000 and b=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
//  Unsigned ops never take the overflow path. DIVU 0x80000000/0xFFFFFFFF takes the normal path: quotient 0, remainder 0x80000000.
//  start_i while busy_o=1: ignored; no queuing, operands are not re-sampled.
//  flush_i: -> IDLE on the next edge from any state. valid_o is not asserted; if the flush lands in DONE, the pulse is killed that cycle.
//   div_result_o keeps its old value.
//   flush_i has priority over start_i in the same cycle: the start is dropped.
//  Reset asserted mid-operation: outputs return to reset values immediately (asynchronously), and no valid_o follows.
//  Arithmetic: negation is two's complement modulo 2^XLEN; no X propagation; div_op_type_i values outside the enum are not possible (2-bit field).
// STRUCTURE
//  defines.v: DIV_OP_DIV=2'b00, DIV_OP_DIVU=2'b01, DIV_OP_REM=2'b10, DIV_OP_REMU=2'b11; state encodings DIV_ST_IDLE/CALC/FIXUP/DONE.
//  Sub-module div_step (combinational): inputs {R,Q}, |b|; outputs the next {R,Q}. Holds the shift, subtract and select for one step.
//  The FSM, counter and sign fixup stay in divider.
// TESTING
//  DIVU 100/7 -> 14 (0x0000000E); REMU 100/7 -> 2. valid_o pulses exactly XLEN+2 cycles after accept.
//  DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1). REM 7/-2 -> 1; DIV 7/-2 -> 0xFFFFFFFD.
//  DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5. valid_o comes 1 cycle after accept; busy_o never rises.
//  DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both via the fast path; DIVU same operands -> 0 after the full latency.
//  Issue 100/7 DIVU, assert flush_i at accept+10 -> busy_o=0 next cycle, no valid_o.
//   Then start 9/3 DIV -> 3.
//   Also check: start_i held while busy_o=1 changes nothing.
//   Also check: flush_i and start_i in the same cycle -> no accept.
//  Back-to-back: assert start_i in the DONE cycle -> second op accepted with no idle gap; the result of each op is correct.
//   Also assert rst_n_i=0 mid-CALC -> all outputs are 0 immediately.

Source files
------------

// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : divider_pkg
//  Description : Shared operation and state encodings for the iterative
//                radix-2 restoring divider, plus small op-decode helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    // Operation select carried on div_op_type_i.
    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    // Controller states.
    typedef enum logic [1:0] {
        DIV_ST_IDLE  = 2'b00,
        DIV_ST_CALC  = 2'b01,
        DIV_ST_FIXUP = 2'b10,
        DIV_ST_DONE  = 2'b11
    } div_state_e;

    // True for REM/REMU: the remainder is the architectural result.
    function automatic logic is_rem_op(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

    // True for DIV/REM: operands are two's complement.
    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : divider_div_step
//  Description : One combinational restoring-division step. Shifts {R,Q}
//                left by one, trial-subtracts the divisor from R and keeps
//                the difference (and a quotient bit of 1) when it does not
//                borrow.
//  Ports       : rem_in/quo_in   current remainder (XLEN+1) and quotient
//                divisor         magnitude of the divisor
//                rem_out/quo_out next remainder and quotient
//  Revision    : 1.0 - initial release
// ============================================================================
module divider_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    // One extra bit on the shifted remainder so the subtraction's borrow
    // shows up cleanly in the top bit of the difference.
    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;
    logic            borrow;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {2'b00, divisor};
        borrow  = diff[XLEN+1];
        rem_out = borrow ? shifted[XLEN:0] : diff[XLEN:0];
        quo_out = {quo_in[XLEN-2:0], ~borrow};
    end

endmodule
`default_nettype wire

// File: rtl/divider.sv
`default_nettype none
// ============================================================================
//  Module      : divider
//  Description : Multi-cycle RV32M divider (DIV/DIVU/REM/REMU). Accepts an
//                operation when start_i is high and the unit is not busy,
//                runs XLEN restoring steps, applies signs, then pulses
//                valid_o for one cycle. Divide-by-zero and signed overflow
//                bypass the iteration and complete on the next cycle.
//  Ports       : clk_i, rst_n_i (async, active low)
//                start_i, flush_i, operand_a_i, operand_b_i, div_op_type_i
//                busy_o, valid_o, div_result_o
//  Revision    : 1.0 - initial release
// ============================================================================
module divider
    import divider_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic [1:0]      div_op_type_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] div_result_o
);

    localparam int              CNT_W   = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONE     = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    div_state_e       state;
    logic [CNT_W-1:0] count;
    logic [XLEN:0]    rem_q;
    logic [XLEN-1:0]  quo_q;
    logic [XLEN-1:0]  divisor;
    logic [1:0]       op_q;
    logic             neg_q;
    logic             neg_r;
    logic             busy;
    logic             valid;
    logic [XLEN-1:0]  result;

    logic [XLEN:0]    rem_next;
    logic [XLEN-1:0]  quo_next;

    // Decode of the incoming request, used only on the accept edge.
    logic             in_signed;
    logic             in_rem;
    logic [XLEN-1:0]  a_abs;
    logic [XLEN-1:0]  b_abs;
    logic             div_by_zero;
    logic             overflow;
    logic [XLEN-1:0]  quo_fixed;
    logic [XLEN-1:0]  rem_fixed;

    always_comb begin
        in_signed   = is_signed_op(div_op_type_i);
        in_rem      = is_rem_op(div_op_type_i);
        a_abs       = (in_signed && operand_a_i[XLEN-1]) ? (~operand_a_i + ONE) : operand_a_i;
        b_abs       = (in_signed && operand_b_i[XLEN-1]) ? (~operand_b_i + ONE) : operand_b_i;
        div_by_zero = (operand_b_i == '0);
        overflow    = in_signed && (operand_a_i == MIN_NEG) && (operand_b_i == ALL_ONE);
        quo_fixed   = neg_q ? (~quo_q + ONE) : quo_q;
        rem_fixed   = neg_r ? (~rem_q[XLEN-1:0] + ONE) : rem_q[XLEN-1:0];
    end

    divider_div_step #(
        .XLEN    (XLEN)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor),
        .rem_out (rem_next),
        .quo_out (quo_next)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= DIV_ST_IDLE;
            count   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            divisor <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            result  <= '0;
        end else begin
            valid <= 1'b0;
            if (flush_i) begin
                // Flush wins over everything, including a same-cycle start.
                state <= DIV_ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    DIV_ST_IDLE, DIV_ST_DONE: begin
                        // DONE accepts too, so ops can issue back to back.
                        if (start_i) begin
                            op_q  <= div_op_type_i;
                            neg_q <= in_signed && (operand_a_i[XLEN-1] ^ operand_b_i[XLEN-1]);
                            neg_r <= in_signed && operand_a_i[XLEN-1];
                            if (div_by_zero) begin
                                result <= in_rem ? operand_a_i : ALL_ONE;
                                state  <= DIV_ST_DONE;
                                valid  <= 1'b1;
                            end else if (overflow) begin
                                result <= in_rem ? '0 : MIN_NEG;
                                state  <= DIV_ST_DONE;
                                valid  <= 1'b1;
                            end else begin
                                rem_q   <= '0;
                                quo_q   <= a_abs;
                                divisor <= b_abs;
                                count   <= LAST_CNT;
                                state   <= DIV_ST_CALC;
                                busy    <= 1'b1;
                            end
                        end else begin
                            state <= DIV_ST_IDLE;
                        end
                    end
                    DIV_ST_CALC: begin
                        rem_q <= rem_next;
                        quo_q <= quo_next;
                        count <= count - 1'b1;
                        if (count == '0) begin
                            state <= DIV_ST_FIXUP;
                        end
                    end
                    DIV_ST_FIXUP: begin
                        result <= is_rem_op(op_q) ? rem_fixed : quo_fixed;
                        state  <= DIV_ST_DONE;
                        busy   <= 1'b0;
                        valid  <= 1'b1;
                    end
                    default: begin
                        state <= DIV_ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy_o       = busy;
    assign valid_o      = valid;
    assign div_result_o = result;

endmodule
`default_nettype wire

// File: tb/tb_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_divider
//  Description : Self-checking bench for divider: directed vector table,
//                multi-cycle corner sequences (flush, ignored start,
//                back-to-back issue, mid-operation reset) and randomized
//                operations against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_divider;

    localparam int XLEN     = 32;
    localparam int NORM_LAT = XLEN + 2;
    localparam int MAX_WAIT = 100;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            flush;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [1:0]      op;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;

    int checks   = 0;
    int failures = 0;

    divider #(.XLEN(XLEN)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .flush_i       (flush),
        .operand_a_i   (opa),
        .operand_b_i   (opb),
        .div_op_type_i (op),
        .busy_o        (busy),
        .valid_o       (valid),
        .div_result_o  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [31:0]     exp;
        int              lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics from plain arithmetic.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic   rem;
        logic   sgn;
        rem = o[1];
        sgn = !o[0];
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return rem ? r[31:0] : q[31:0];
        end
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic int model_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return NORM_LAT;
    endfunction

    // Issue one op and wait for valid_o. lat = cycles after the accept edge.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat,
                          output logic busy_after, output logic busy_seen);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat        = 1;
        busy_after = busy;
        busy_seen  = busy;
        while (!valid && lat < MAX_WAIT) begin
            @(posedge clk); #1;
            lat++;
            busy_seen = busy_seen | busy;
        end
        res = result;
    endtask

    // Watch n cycles; report whether valid_o ever rose.
    task automatic watch_no_valid(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            seen = seen | valid;
        end
    endtask

    vec_t        vecs[$];
    logic [31:0] res;
    int          lat;
    logic        b_after, b_seen, seen;
    logic [31:0] held;

    initial begin
        rst_n = 1'b0; start = 1'b0; flush = 1'b0;
        opa = '0; opb = '0; op = 2'b00;

        vecs.push_back('{2'b01, 32'd100,        32'd7,          32'h0000_000E, NORM_LAT});
        vecs.push_back('{2'b11, 32'd100,        32'd7,          32'h0000_0002, NORM_LAT});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, NORM_LAT});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, NORM_LAT});
        vecs.push_back('{2'b10, 32'd7,          32'hFFFF_FFFE,  32'h0000_0001, NORM_LAT});
        vecs.push_back('{2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, NORM_LAT});
        vecs.push_back('{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF, 1});
        vecs.push_back('{2'b10, 32'd5,          32'd0,          32'h0000_0005, 1});
        vecs.push_back('{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1});
        vecs.push_back('{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1});
        vecs.push_back('{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, NORM_LAT});
        vecs.push_back('{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, NORM_LAT});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, NORM_LAT});

        // Reset state.
        #12;
        check("reset_busy",   {31'd0, busy},  32'd0);
        check("reset_valid",  {31'd0, valid}, 32'd0);
        check("reset_result", result,         32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed table.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, b_after, b_seen);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            if (vecs[i].lat == 1)
                check($sformatf("vec%0d_fast_no_busy", i), {31'd0, b_seen}, 32'd0);
        end

        // Flush at accept+10, then a fresh op.
        repeat (2) @(posedge clk);
        held = result;
        @(negedge clk);
        start = 1'b1; op = 2'b01; opa = 32'd100; opb = 32'd7;
        @(posedge clk); #1; start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_busy_low", {31'd0, busy}, 32'd0);
        watch_no_valid(40, seen);
        check("flush_no_valid", {31'd0, seen}, 32'd0);
        check("flush_result_held", result, held);
        run_op(2'b00, 32'd9, 32'd3, res, lat, b_after, b_seen);
        check("post_flush_div", res, 32'd3);

        // start held while busy must not re-sample operands.
        @(negedge clk);
        start = 1'b1; op = 2'b01; opa = 32'd100; opb = 32'd7;
        @(posedge clk); #1;
        opa = 32'd50; opb = 32'd5; op = 2'b11;
        lat = 1;
        while (!valid && lat < MAX_WAIT) begin
            if (lat == 20) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check("held_start_result", result, 32'h0000_000E);
        check("held_start_latency", 32'(lat), 32'(NORM_LAT));
        repeat (2) @(posedge clk);

        // flush and start together: no accept.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b01; opa = 32'd5; opb = 32'd0;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);
        check("flush_start_valid", {31'd0, valid}, 32'd0);
        watch_no_valid(5, seen);
        check("flush_start_no_valid", {31'd0, seen}, 32'd0);

        // Back-to-back: second start lands in the DONE cycle.
        run_op(2'b01, 32'd100, 32'd7, res, lat, b_after, b_seen);
        check("b2b_first", res, 32'h0000_000E);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, res, lat, b_after, b_seen);
        check("b2b_second_busy_now", {31'd0, b_after}, 32'd1);
        check("b2b_second", res, 32'hFFFF_FFFF);
        check("b2b_second_latency", 32'(lat), 32'(NORM_LAT));

        // Randomized against the model.
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       rb = 32'd0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2, 3:    rb = 32'($urandom_range(1, 20)) ^ ({32{$urandom_range(0, 1) == 1}});
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, res, lat, b_after, b_seen);
            check($sformatf("rand%0d_op%0d_result", n, ro), res, model(ro, ra, rb));
            check($sformatf("rand%0d_latency", n), 32'(lat), 32'(model_lat(ro, ra, rb)));
        end

        // Reset mid-CALC: outputs clear immediately, no valid afterwards.
        @(negedge clk);
        start = 1'b1; op = 2'b01; opa = 32'd1000; opb = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_busy",   {31'd0, busy},  32'd0);
        check("midreset_valid",  {31'd0, valid}, 32'd0);
        check("midreset_result", result,         32'd0);
        @(negedge clk); rst_n = 1'b1;
        watch_no_valid(40, seen);
        check("midreset_no_valid", {31'd0, seen}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
